sync_delay: RTL and testbench

SYNC_DELAY -- requirements
Module: sync_delay

---
 rtl/general_lib_pkg.sv | 23 ++
 rtl/sync_delay_if.sv | 26 ++
 rtl/sync_delay_ctr.sv | 44 ++++
 rtl/sync_delay.sv | 99 +++++++++
 tb/tb_sync_delay.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/general_lib_pkg.sv
// Shared definitions for the sync delay block.
// - state_e : tracker state (Idle: nothing in flight, Count: one sync in flight)
// - clog2   : ceil(log2(value)), used to size the down-counter
package general_lib_pkg;

  typedef enum logic {
    Idle  = 1'b0,
    Count = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned     result;
    longint unsigned pow;
    result = 0;
    pow    = 1;
    while (pow < longint'(value)) begin
      pow    = pow << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_delay_if.sv
// Bundle of the sync delay control/status signals.
// - ce          : clock enable, state advances only when high
// - sync_in     : incoming sync pulse
// - clr_overrun : synchronous clear of the sticky overrun flag (ignores ce)
// - sync_out    : sync_in delayed by DELAY ce-qualified edges
// - busy        : a sync is in flight
// - overrun     : sticky, a sync arrived while another was in flight
// master drives the controls, slave is the sync_delay block.
interface sync_delay_if;
  logic ce;
  logic sync_in;
  logic clr_overrun;
  logic sync_out;
  logic busy;
  logic overrun;

  modport master (
    output ce, sync_in, clr_overrun,
    input  sync_out, busy, overrun
  );

  modport slave (
    input  ce, sync_in, clr_overrun,
    output sync_out, busy, overrun
  );
endinterface

// File: rtl/sync_delay_ctr.sv
// Loadable down-counter with clock enable and terminal-count flag.
// - clk, rst_n : clock, asynchronous active-low reset (count cleared to 0)
// - ce_i       : enable; load and decrement only act when high
// - load_i     : load LoadVal (wins over decrement)
// - dec_i      : decrement by one, saturating at zero
// - tc_o       : count is zero
module sync_delay_ctr #(
  parameter int unsigned Width   = 1,
  parameter int unsigned LoadVal = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  localparam logic [Width-1:0] LoadCnt = Width'(LoadVal);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ce_i) begin
      if (load_i) begin
        cnt_d = LoadCnt;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - Width'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sync_delay.sv
// Sync pulse delay matched to a DELAY-deep BRAM data delay line, using a
// counter instead of a shift register. Tracks one outstanding sync.
// - clk, rst_n : clock, asynchronous active-low reset
// - sd         : sync_delay_if.slave (ce, sync_in, clr_overrun in;
//                sync_out, busy, overrun out)
// Build option: define SYNC_DELAY_RETRIGGER_EN so that a sync arriving while
// one is in flight restarts the delay instead of flagging overrun.
module sync_delay
  import general_lib_pkg::*;
#(
  parameter int unsigned DELAY    = 1024,
  parameter int unsigned CTR_BITS = clog2(DELAY + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  sync_delay_if.slave  sd
);

  // Accept edge is delay stage 1, so the terminal edge is DELAY-1 edges later:
  // load DELAY-2 and fire when the count reaches zero while in Count.
  localparam int unsigned CtrLoad     = (DELAY > 1) ? DELAY - 2 : 0;
  localparam bit          SingleStage = (DELAY == 1);

  state_e state_q, state_d;
  logic   sync_out_q, sync_out_d;
  logic   busy_q, busy_d;
  logic   overrun_q, overrun_d;
  logic   ctr_tc;
  logic   term;
  logic   sample;
  logic   load;
  logic   overrun_set;

  sync_delay_ctr #(
    .Width   (CTR_BITS),
    .LoadVal (CtrLoad)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce_i   (sd.ce),
    .load_i (load),
    .dec_i  (state_q == Count),
    .tc_o   (ctr_tc)
  );

  always_comb begin
    term   = (state_q == Count) && ctr_tc;
    sample = sd.ce && sd.sync_in;
`ifdef SYNC_DELAY_RETRIGGER_EN
    // Any new sync restarts the delay; an earlier in-flight sync is dropped.
    load        = sample && !SingleStage;
    overrun_set = 1'b0;
`else
    // A sync on the terminal edge is accepted, since the slot frees up then.
    load        = sample && !SingleStage && ((state_q == Idle) || term);
    overrun_set = sample && (state_q == Count) && !term;
`endif

    state_d    = state_q;
    sync_out_d = sync_out_q;
    if (sd.ce) begin
      sync_out_d = term || (SingleStage && sd.sync_in);
      if (load) begin
        state_d = Count;
      end else if (term) begin
        state_d = Idle;
      end
    end
    busy_d = (state_d == Count);

    // A new overrun event beats a simultaneous clear.
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (sd.clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= Idle;
      sync_out_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_out_q <= sync_out_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sd.sync_out = sync_out_q;
  assign sd.busy     = busy_q;
  assign sd.overrun  = overrun_q;

endmodule

// File: tb/tb_sync_delay.sv
// Directed bench for sync_delay at DELAY=1024, 8 and 1. Cycle c denotes the
// interval after clock edge c; inputs driven in cycle c are sampled by edge c+1.
module tb_sync_delay;

  logic clk;
  logic rst_n;

  sync_delay_if ifa ();
  sync_delay_if ifb ();
  sync_delay_if ifc ();

  sync_delay #(.DELAY(1024)) u_a (.clk(clk), .rst_n(rst_n), .sd(ifa));
  sync_delay #(.DELAY(8))    u_b (.clk(clk), .rst_n(rst_n), .sd(ifb));
  sync_delay #(.DELAY(1))    u_c (.clk(clk), .rst_n(rst_n), .sd(ifc));

  int   checks = 0;
  int   errors = 0;
  logic exp_so, exp_busy, exp_ov;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.ce = 1'b1; ifa.sync_in = 1'b1; ifa.clr_overrun = 1'b0;
    ifb.ce = 1'b1; ifb.sync_in = 1'b1; ifb.clr_overrun = 1'b0;
    ifc.ce = 1'b1; ifc.sync_in = 1'b1; ifc.clr_overrun = 1'b0;
    repeat (3) next_cycle();
    checks++; if ({ifa.sync_out, ifa.busy, ifa.overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_a: got %b expected 000", {ifa.sync_out, ifa.busy, ifa.overrun});
    end
    checks++; if ({ifb.sync_out, ifb.busy, ifb.overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_b: got %b expected 000", {ifb.sync_out, ifb.busy, ifb.overrun});
    end
    checks++; if ({ifc.sync_out, ifc.busy, ifc.overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_c: got %b expected 000", {ifc.sync_out, ifc.busy, ifc.overrun});
    end
    ifa.sync_in = 1'b0; ifb.sync_in = 1'b0; ifc.sync_in = 1'b0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_long_delay();
    for (int c = 0; c <= 1040; c++) begin
      ifa.sync_in = (c == 10);
      exp_so   = (c == 1034);
      exp_busy = (c >= 11 && c <= 1033);
      checks++; if (ifa.sync_out !== exp_so) begin
        errors++; $display("FAIL long_sync_out c=%0d: got %b expected %b", c, ifa.sync_out, exp_so);
      end
      checks++; if (ifa.busy !== exp_busy) begin
        errors++; $display("FAIL long_busy c=%0d: got %b expected %b", c, ifa.busy, exp_busy);
      end
      next_cycle();
    end
    ifa.sync_in = 1'b0;
  endtask

  task automatic test_ce_toggle();
    logic [7:0] sr;
    sr = '0;
    for (int c = 0; c <= 24; c++) begin
      ifb.ce      = (c % 2 == 0);
      ifb.sync_in = (c == 2);
      exp_so   = (c == 17 || c == 18);
      exp_busy = (c >= 3 && c <= 16);
      checks++; if (ifb.sync_out !== exp_so) begin
        errors++; $display("FAIL ce_sync_out c=%0d: got %b expected %b", c, ifb.sync_out, exp_so);
      end
      checks++; if (ifb.sync_out !== sr[7]) begin
        errors++; $display("FAIL ce_vs_shiftreg c=%0d: got %b expected %b", c, ifb.sync_out, sr[7]);
      end
      checks++; if (ifb.busy !== exp_busy) begin
        errors++; $display("FAIL ce_busy c=%0d: got %b expected %b", c, ifb.busy, exp_busy);
      end
      if (ifb.ce) sr = {sr[6:0], ifb.sync_in};
      next_cycle();
    end
    ifb.ce = 1'b1; ifb.sync_in = 1'b0;
  endtask

  task automatic test_overrun();
    for (int c = 0; c <= 24; c++) begin
      ifb.sync_in     = (c == 0 || c == 4);
      ifb.clr_overrun = (c == 20);
`ifdef SYNC_DELAY_RETRIGGER_EN
      exp_so   = (c == 12);
      exp_busy = (c >= 1 && c <= 11);
      exp_ov   = 1'b0;
`else
      exp_so   = (c == 8);
      exp_busy = (c >= 1 && c <= 7);
      exp_ov   = (c >= 5 && c <= 20);
`endif
      checks++; if (ifb.sync_out !== exp_so) begin
        errors++; $display("FAIL ovr_sync_out c=%0d: got %b expected %b", c, ifb.sync_out, exp_so);
      end
      checks++; if (ifb.busy !== exp_busy) begin
        errors++; $display("FAIL ovr_busy c=%0d: got %b expected %b", c, ifb.busy, exp_busy);
      end
      checks++; if (ifb.overrun !== exp_ov) begin
        errors++; $display("FAIL ovr_flag c=%0d: got %b expected %b", c, ifb.overrun, exp_ov);
      end
      next_cycle();
    end
    ifb.sync_in = 1'b0; ifb.clr_overrun = 1'b0;
  endtask

  // Clear coinciding with an overrun event, then a clear while ce is low.
  task automatic test_overrun_priority();
    for (int c = 0; c <= 14; c++) begin
      ifb.sync_in     = (c == 0 || c == 3);
      ifb.clr_overrun = (c == 3 || c == 10);
      ifb.ce          = (c != 10);
`ifdef SYNC_DELAY_RETRIGGER_EN
      exp_so = (c == 12);
      exp_ov = 1'b0;
`else
      exp_so = (c == 8);
      exp_ov = (c >= 4 && c <= 10);
`endif
      checks++; if (ifb.sync_out !== exp_so) begin
        errors++; $display("FAIL prio_sync_out c=%0d: got %b expected %b", c, ifb.sync_out, exp_so);
      end
      checks++; if (ifb.overrun !== exp_ov) begin
        errors++; $display("FAIL prio_flag c=%0d: got %b expected %b", c, ifb.overrun, exp_ov);
      end
      next_cycle();
    end
    ifb.sync_in = 1'b0; ifb.clr_overrun = 1'b0; ifb.ce = 1'b1;
  endtask

  // Second sync one cycle after the terminal edge, then exactly on it.
  task automatic test_back_to_back();
    int s2;
    for (int v = 0; v < 2; v++) begin
      s2 = (v == 0) ? 8 : 7;
      for (int c = 0; c <= 20; c++) begin
        ifb.sync_in = (c == 0 || c == s2);
        exp_so   = (c == 8 || c == s2 + 8);
        exp_busy = (v == 0) ? ((c >= 1 && c <= 7) || (c >= 9 && c <= 15)) : (c >= 1 && c <= 14);
        checks++; if (ifb.sync_out !== exp_so) begin
          errors++; $display("FAIL b2b%0d_sync_out c=%0d: got %b expected %b", v, c, ifb.sync_out, exp_so);
        end
        checks++; if (ifb.busy !== exp_busy) begin
          errors++; $display("FAIL b2b%0d_busy c=%0d: got %b expected %b", v, c, ifb.busy, exp_busy);
        end
        checks++; if (ifb.overrun !== 1'b0) begin
          errors++; $display("FAIL b2b%0d_overrun c=%0d: got %b expected 0", v, c, ifb.overrun);
        end
        next_cycle();
      end
    end
    ifb.sync_in = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    for (int c = 0; c <= 18; c++) begin
      ifb.sync_in = (c == 0 || c == 4 || c == 6);
      exp_so   = (c == 14);
      exp_busy = (c >= 1 && c <= 3) || (c >= 7 && c <= 13);
      checks++; if (ifb.sync_out !== exp_so) begin
        errors++; $display("FAIL rst_sync_out c=%0d: got %b expected %b", c, ifb.sync_out, exp_so);
      end
      checks++; if (ifb.busy !== exp_busy) begin
        errors++; $display("FAIL rst_busy c=%0d: got %b expected %b", c, ifb.busy, exp_busy);
      end
      if (c == 3) begin
        #4 rst_n = 1'b0;
        #1;
        checks++; if ({ifb.sync_out, ifb.busy, ifb.overrun} !== 3'b000) begin
          errors++; $display("FAIL rst_async: got %b expected 000", {ifb.sync_out, ifb.busy, ifb.overrun});
        end
      end
      if (c == 5) begin
        #4 rst_n = 1'b1;
      end
      next_cycle();
    end
    ifb.sync_in = 1'b0;
  endtask

  task automatic test_delay_one();
    for (int c = 0; c <= 6; c++) begin
      ifc.sync_in = (c <= 2);
      exp_so = (c >= 1 && c <= 3);
      checks++; if (ifc.sync_out !== exp_so) begin
        errors++; $display("FAIL d1_sync_out c=%0d: got %b expected %b", c, ifc.sync_out, exp_so);
      end
      checks++; if ({ifc.busy, ifc.overrun} !== 2'b00) begin
        errors++; $display("FAIL d1_busy_overrun c=%0d: got %b expected 00", c, {ifc.busy, ifc.overrun});
      end
      next_cycle();
    end
    ifc.sync_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_long_delay();
    test_ce_toggle();
    test_overrun();
    test_overrun_priority();
    test_back_to_back();
    test_reset_mid_count();
    test_delay_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
